// File: rtl/decoder_3x8_using_2x4.sv
// 3-to-8 one-hot decoder built from two enabled 2-to-4 stages, with a registered output.
// Select {c,a,b} picks one of eight lines; c steers the decode to the upper or lower stage.

module decoder_2x4 (
  input  logic       en,
  input  logic       s1,
  input  logic       s0,
  output logic [3:0] d
);

  always_comb begin
    // NOTE: give every combinational output a default before the selective write, or synthesis infers a latch.
    d           = '0;
    d[{s1, s0}] = en;
  end

endmodule

module decoder_3x8_using_2x4 (
  input  logic       clk,
  input  logic       rst,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  output logic [7:0] y
);

  logic [7:0] next_y;

  // Only the stage that c enables drives a 1, so exactly one line is hot for known inputs.
  decoder_2x4 u_low (
    .en (~c),
    .s1 (a),
    .s0 (b),
    .d  (next_y[3:0])
  );

  decoder_2x4 u_high (
    .en (c),
    .s1 (a),
    .s0 (b),
    .d  (next_y[7:4])
  );

  // Reset clears y at once; decoding resumes on the first clk edge after release.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) y <= 8'h00;
    else     y <= next_y;
  end

endmodule

// File: tb/tb_decoder_3x8_using_2x4.sv
// Self-checking bench for decoder_3x8_using_2x4: directed scenarios plus randomized decode
// checked against a shift-based reference model.

module tb_decoder_3x8_using_2x4;

  logic       clk;
  logic       rst;
  logic       a;
  logic       b;
  logic       c;
  logic [7:0] y;

  int n_checks = 0;
  int n_fail   = 0;

  decoder_3x8_using_2x4 dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .c   (c),
    .y   (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the selected line is simply bit number {c,a,b}.
  function automatic logic [7:0] model(input logic [2:0] sel);
    logic [7:0] r;
    r = 8'd0;
    r[sel] = 1'b1;
    return r;
  endfunction

  task automatic drive(input logic [2:0] sel);
    {c, a, b} = sel;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(3'b111);
    #1;
    n_checks++;
    if (y !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_async: y=%h expected %h", y, 8'h00);
    end
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_held: y=%h expected %h", y, 8'h00);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (y !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_release_before_edge: y=%h expected %h", y, 8'h00);
    end
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h80) begin
      n_fail++;
      $display("FAIL reset_first_edge: y=%h expected %h", y, 8'h80);
    end
  endtask

  task automatic test_sweep(input logic cbit);
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive({cbit, i[1:0]});
      exp = cbit ? (8'h10 << i) : (8'h01 << i);
      @(posedge clk); #1;
      n_checks++;
      if (y !== exp || y !== model({cbit, i[1:0]})) begin
        n_fail++;
        $display("FAIL sweep_c%0d_ab%0d: y=%h expected %h", cbit, i, y, exp);
      end
    end
  endtask

  task automatic test_between_edges();
    @(negedge clk);
    drive(3'b000);
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h01) begin
      n_fail++;
      $display("FAIL between_edges_start: y=%h expected %h", y, 8'h01);
    end
    #2;
    drive(3'b101);
    #1;
    n_checks++;
    if (y !== 8'h01) begin
      n_fail++;
      $display("FAIL between_edges_hold: y=%h expected %h", y, 8'h01);
    end
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h20) begin
      n_fail++;
      $display("FAIL between_edges_update: y=%h expected %h", y, 8'h20);
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    drive(3'b110);
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h40) begin
      n_fail++;
      $display("FAIL midrst_before: y=%h expected %h", y, 8'h40);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (y !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_async_clear: y=%h expected %h", y, 8'h00);
    end
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (y !== 8'h00) begin
      n_fail++;
      $display("FAIL midrst_released_no_edge: y=%h expected %h", y, 8'h00);
    end
    @(posedge clk); #1;
    n_checks++;
    if (y !== 8'h40) begin
      n_fail++;
      $display("FAIL midrst_resume: y=%h expected %h", y, 8'h40);
    end
  endtask

  task automatic test_random();
    logic [2:0] sel;
    logic [7:0] exp;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      sel = 3'($urandom_range(0, 7));
      drive(sel);
      exp = 8'd1 << sel;
      @(posedge clk); #1;
      n_checks++;
      if (y !== exp) begin
        n_fail++;
        $display("FAIL random_decode[%0d]: sel=%0d y=%h expected %h", i, sel, y, exp);
      end
      n_checks++;
      if (!$onehot(y)) begin
        n_fail++;
        $display("FAIL random_onehot[%0d]: y=%h expected one bit set", i, y);
      end
      // Scramble the selects mid-cycle; only the value at the next edge should count.
      drive(3'($urandom_range(0, 7)));
    end
  endtask

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    drive(3'b000);
    test_reset();
    test_sweep(1'b0);
    test_sweep(1'b1);
    test_between_edges();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
